// File: rtl/bmlp_pkg.sv
// Shared definitions for the binary MLP datapath: layer codes and default sizes.
package bmlp_pkg;

    typedef enum logic [2:0] {
        LAYER_HID = 3'b000,
        LAYER_IN  = 3'b001,
        LAYER_OUT = 3'b010,
        LAYER_END = 3'b100
    } layer_e;

    localparam int NUM_CLASSES = 11;
    localparam int ACC_W       = 8;
    localparam int CLS_W       = 4;

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over the output-layer scores of one frame.
// Strict greater-than keeps the lower index on ties; the first score of a
// frame always seeds the tracker. The caller stops presenting scores once
// all classes of the frame have been seen.
module argmax_tracker #(
    parameter int ACC_W = bmlp_pkg::ACC_W,
    parameter int CLS_W = bmlp_pkg::CLS_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic signed [ACC_W-1:0] score,
    input  logic                    score_valid,
    output logic        [CLS_W-1:0] best_idx,
    output logic        [CLS_W-1:0] count
);
    import bmlp_pkg::*;

    logic signed [ACC_W-1:0] best;

    // Track best score and its index; clear wins over a same-cycle score.
    always_ff @(posedge clk) begin
        // NOTE: rst is synchronous, so it is tested inside the clocked block
        // and kept out of the sensitivity list.
        if (!rst || !clear) begin
            best     <= '0;
            best_idx <= '0;
            count    <= '0;
        end else if (score_valid) begin
            if (count == '0 || score > best) begin
                best     <= score;
                best_idx <= count;
            end
            count <= count + CLS_W'(1);
        end
    end

endmodule

// File: rtl/xnor_popcount_unit.sv
// Binary-neuron compute unit: XNOR of activation and weight bits accumulated
// as a saturating signed +/-1 popcount. Each neuron end either emits a
// binarized bit (hidden/input layers) or feeds the argmax tracker (output
// layer); the winning class is reported when the layer code moves to END.
module xnor_popcount_unit #(
    parameter int ACC_W       = bmlp_pkg::ACC_W,
    parameter int THRESH      = 0,
    parameter int NUM_CLASSES = bmlp_pkg::NUM_CLASSES,
    parameter int CLS_W       = bmlp_pkg::CLS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cu_rst,
    input  logic             g_reg_rst7,
    input  logic [2:0]       layer,
    input  logic             act_bit,
    input  logic             wgt_bit,
    output logic             rf_wdata,
    output logic             rf_wvalid,
    output logic [ACC_W-1:0] acc_dbg,
    output logic [CLS_W-1:0] class_out,
    output logic             class_valid
);
    import bmlp_pkg::*;

    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   STEP_UP   = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0]   STEP_DN   = -(ACC_W+1)'(1);
    localparam logic signed [ACC_W-1:0] THRESH_W  = ACC_W'(THRESH);
    localparam logic        [CLS_W-1:0] CNT_LIMIT = CLS_W'(NUM_CLASSES);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   sum_ext;
    logic                    cu_rst_d;
    logic [2:0]              layer_d;
    logic                    end_ev;
    logic                    frame_end;
    logic                    is_out;
    logic                    score_valid;
    logic [CLS_W-1:0]        best_idx;
    logic [CLS_W-1:0]        class_cnt;

    // Next accumulator value: add +/-1 one bit wider, then clamp on overflow.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no
        // latch is inferred.
        sum_ext  = $signed({acc[ACC_W-1], acc}) + ((act_bit == wgt_bit) ? STEP_UP : STEP_DN);
        acc_next = sum_ext[ACC_W-1:0];
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Neuron-end and frame-end edge detects, output-layer score gating.
    always_comb begin
        end_ev      = cu_rst_d & ~cu_rst;
        frame_end   = (layer == LAYER_END) && (layer_d != LAYER_END);
        is_out      = (layer == LAYER_OUT);
        score_valid = end_ev && is_out && (class_cnt < CNT_LIMIT);
    end

    // Accumulator: clear while cu_rst is low, otherwise add the product.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst || !cu_rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    // Delayed copies of cu_rst and layer for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cu_rst_d <= 1'b0;
            layer_d  <= 3'b000;
        end else begin
            cu_rst_d <= cu_rst;
            layer_d  <= layer;
        end
    end

    // Binarizer: acc still holds the final sum on the end_ev edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wdata  <= 1'b0;
            rf_wvalid <= 1'b0;
        end else begin
            rf_wvalid <= end_ev & ~is_out;
            if (end_ev && !is_out) begin
                rf_wdata <= (acc >= THRESH_W);
            end
        end
    end

    // Frame-end report of the winning class; class_out holds between frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            class_out   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= frame_end;
            if (frame_end) begin
                class_out <= best_idx;
            end
        end
    end

    argmax_tracker #(
        .ACC_W (ACC_W),
        .CLS_W (CLS_W)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .clear       (g_reg_rst7),
        .score       (acc),
        .score_valid (score_valid),
        .best_idx    (best_idx),
        .count       (class_cnt)
    );

    assign acc_dbg = acc;

endmodule

// File: tb/tb_xnor_popcount_unit.sv
// Scoreboard bench for xnor_popcount_unit: randomized neurons and frames
// against an integer reference model of the popcount and argmax rules.
module tb_xnor_popcount_unit;
    import bmlp_pkg::*;

    localparam int ACC_W  = 8;
    localparam int THRESH = 0;
    localparam int NC     = 11;
    localparam int CLS_W  = 4;

    logic             clk;
    logic             rst;
    logic             cu_rst;
    logic             g_reg_rst7;
    logic [2:0]       layer;
    logic             act_bit;
    logic             wgt_bit;
    logic             rf_wdata;
    logic             rf_wvalid;
    logic [ACC_W-1:0] acc_dbg;
    logic [CLS_W-1:0] class_out;
    logic             class_valid;

    xnor_popcount_unit #(
        .ACC_W       (ACC_W),
        .THRESH      (THRESH),
        .NUM_CLASSES (NC),
        .CLS_W       (CLS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cu_rst      (cu_rst),
        .g_reg_rst7  (g_reg_rst7),
        .layer       (layer),
        .act_bit     (act_bit),
        .wgt_bit     (wgt_bit),
        .rf_wdata    (rf_wdata),
        .rf_wvalid   (rf_wvalid),
        .acc_dbg     (acc_dbg),
        .class_out   (class_out),
        .class_valid (class_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_rf[$];   // expected rf_wdata per rf_wvalid pulse
    int exp_cls[$];  // expected class_out per class_valid pulse
    int scores[$];   // model: output-layer scores since last tracker clear
    bit prods[$];    // products of the next neuron (1 = match)

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        int hi = (1 << (ACC_W - 1)) - 1;
        int lo = -(1 << (ACC_W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int argmax_model();
        int idx = 0;
        int lim = (scores.size() < NC) ? scores.size() : NC;
        for (int i = 1; i < lim; i++) begin
            if (scores[i] > scores[idx]) idx = i;
        end
        return idx;
    endfunction

    // Monitor: every output pulse pops and compares one scoreboard entry.
    always @(negedge clk) begin
        if (rf_wvalid) begin
            if (exp_rf.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rf_wvalid_unexpected: got pulse expected none (data %0d)", rf_wdata);
            end else begin
                check("rf_wdata", int'(rf_wdata), exp_rf.pop_front());
            end
        end
        if (class_valid) begin
            if (exp_cls.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL class_valid_unexpected: got pulse expected none (class %0d)", class_out);
            end else begin
                check("class_out", int'(class_out), exp_cls.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_const(input int n, input bit v);
        prods.delete();
        repeat (n) prods.push_back(v);
    endtask

    task automatic build_rand(input int n);
        prods.delete();
        repeat (n) prods.push_back(1'($urandom_range(0, 1)));
    endtask

    // Any neuron whose plain sum equals s (small |s|, no saturation).
    task automatic build_score(input int s);
        int pairs = $urandom_range(0, 3);
        prods.delete();
        if (s == 0 && pairs == 0) pairs = 1;
        for (int i = 0; i < (s < 0 ? -s : s); i++) prods.push_back(s > 0);
        repeat (pairs) begin
            prods.push_front(1'b1);
            prods.push_back(1'b0);
        end
    endtask

    // Drive the products in prods, then clr_len clear cycles.
    task automatic run_neuron(input logic [2:0] lyr, input int clr_len, input bit kill);
        int s = 0;
        bit a;
        layer = lyr;
        foreach (prods[i]) begin
            a       = 1'($urandom_range(0, 1));
            act_bit = a;
            wgt_bit = prods[i] ? a : ~a;
            cu_rst  = 1'b1;
            s       = sat(s + (prods[i] ? 1 : -1));
            tick();
        end
        check("acc_final", int'($signed(acc_dbg)), s);
        cu_rst     = 1'b0;
        g_reg_rst7 = ~kill;
        act_bit    = 1'($urandom_range(0, 1));
        wgt_bit    = 1'($urandom_range(0, 1));
        if (lyr != LAYER_OUT) exp_rf.push_back(int'(s >= THRESH));
        else if (!kill) scores.push_back(s);
        if (kill) scores.delete();
        tick();
        g_reg_rst7 = 1'b1;
        check("acc_cleared", int'($signed(acc_dbg)), 0);
        repeat (clr_len - 1) tick();
    endtask

    task automatic clear_tracker();
        layer      = LAYER_HID;
        g_reg_rst7 = 1'b0;
        scores.delete();
        tick();
        g_reg_rst7 = 1'b1;
    endtask

    task automatic end_frame();
        int e = argmax_model();
        layer = LAYER_END;
        exp_cls.push_back(e);
        tick();
        layer = LAYER_HID;
        tick();
        check("class_out_hold", int'(class_out), e);
    endtask

    initial begin
        rst        = 1'b0;
        cu_rst     = 1'b0;
        g_reg_rst7 = 1'b1;
        layer      = LAYER_HID;
        act_bit    = 1'b0;
        wgt_bit    = 1'b0;
        tick();
        tick();
        check("rst_acc", int'(acc_dbg), 0);
        check("rst_rf_wdata", int'(rf_wdata), 0);
        check("rst_rf_wvalid", int'(rf_wvalid), 0);
        check("rst_class_out", int'(class_out), 0);
        check("rst_class_valid", int'(class_valid), 0);
        rst = 1'b1;
        tick();   // cu_rst low at release: no event
        tick();

        // Directed boundary neurons.
        build_const(48, 1'b1);  run_neuron(LAYER_HID, 1, 1'b0);
        build_const(24, 1'b0);  run_neuron(LAYER_IN, 3, 1'b0);
        prods.delete();
        for (int i = 0; i < 24; i++) prods.push_back(i[0]);
        run_neuron(LAYER_HID, 1, 1'b0);
        build_const(200, 1'b1); run_neuron(LAYER_HID, 1, 1'b0);
        build_const(200, 1'b0); run_neuron(LAYER_HID, 1, 1'b0);
        build_const(150, 1'b1);
        repeat (10) prods.push_back(1'b0);
        run_neuron(LAYER_IN, 2, 1'b0);
        build_const(1, 1'b0);   run_neuron(LAYER_HID, 1, 1'b0);

        // Random hidden/input neurons.
        for (int n = 0; n < 20; n++) begin
            build_rand($urandom_range(1, 80));
            run_neuron($urandom_range(0, 1) != 0 ? LAYER_IN : LAYER_HID,
                       $urandom_range(1, 3), 1'b0);
        end

        // Output frame with a tie at 5: lower index wins.
        begin
            int fs[11] = '{-3, 5, 2, 5, 1, 0, -2, 4, 3, -4, -1};
            clear_tracker();
            foreach (fs[i]) begin
                build_score(fs[i]);
                run_neuron(LAYER_OUT, 1, 1'b0);
            end
            end_frame();
        end

        // Reset mid-accumulation after leaving rf_wdata and class_out nonzero.
        build_const(5, 1'b1); run_neuron(LAYER_HID, 1, 1'b0);
        layer  = LAYER_HID;
        cu_rst = 1'b1;
        repeat (10) begin
            act_bit = 1'($urandom_range(0, 1));
            wgt_bit = act_bit;
            tick();
        end
        rst = 1'b0;
        tick();
        check("midrst_acc", int'(acc_dbg), 0);
        check("midrst_rf_wdata", int'(rf_wdata), 0);
        check("midrst_rf_wvalid", int'(rf_wvalid), 0);
        check("midrst_class_out", int'(class_out), 0);
        check("midrst_class_valid", int'(class_valid), 0);
        scores.delete();
        rst    = 1'b1;
        cu_rst = 1'b0;
        tick();
        tick();
        build_rand(30); run_neuron(LAYER_HID, 1, 1'b0);

        // Frame with extra neurons beyond NUM_CLASSES: the big ones are ignored.
        clear_tracker();
        for (int i = 0; i < 13; i++) begin
            build_score(i < NC ? $urandom_range(0, 12) - 6 : 20 + i);
            run_neuron(LAYER_OUT, 1, 1'b0);
        end
        end_frame();

        // Tracker clear coinciding with an end event: score dropped, count restarts.
        begin
            int pre[4]  = '{9, 2, 3, 10};
            int post[3] = '{5, 4, -2};
            clear_tracker();
            foreach (pre[i]) begin
                build_score(pre[i]);
                run_neuron(LAYER_OUT, 1, i == 3);
            end
            foreach (post[i]) begin
                build_score(post[i]);
                run_neuron(LAYER_OUT, 1, 1'b0);
            end
            end_frame();
        end

        // Random frames; small score range makes ties frequent.
        for (int f = 0; f < 4; f++) begin
            int nn = $urandom_range(1, 13);
            clear_tracker();
            for (int i = 0; i < nn; i++) begin
                build_score($urandom_range(0, 8) - 4);
                run_neuron(LAYER_OUT, $urandom_range(1, 2), 1'b0);
            end
            end_frame();
            build_rand($urandom_range(1, 40));
            run_neuron(LAYER_HID, 1, 1'b0);
        end

        tick();
        tick();
        check("rf_queue_drained", exp_rf.size(), 0);
        check("cls_queue_drained", exp_cls.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
